// File: rtl/memref_copy_initiator.sv
// memref_copy_initiator
//
// Copies up to SIZE words from a source memory (through its memref read port)
// into a destination memory (through its write port), one word per clock.
// A one-cycle tstart pulse starts a copy of min(len, SIZE) words. The copy
// ends with a one-cycle done pulse. The source memory is expected to answer a
// read request with rd_dout_valid/rd_dout exactly one clock later.
//
// Optional feature: define MEMREF_COPY_CHECKSUM_EN to add the `checksum`
// output. It holds the sum mod 2^WIDTH of every word written since the last
// accepted start.
//
// Ports:
//   clk, rst_n       clock (posedge), asynchronous active-low reset
//   tstart, len      start pulse and word count (sampled together)
//   rd_en, rd_addr   source read request / address
//   rd_dout_valid    source read data valid (latency 1)
//   rd_dout          source read data
//   wr_en, wr_addr   destination write enable / address
//   wr_din           destination write data (held when wr_en is low)
//   busy             copy in progress
//   done             one-cycle completion pulse
//   err              sticky protocol error (valid/expectation mismatch)
//   checksum         sum of written words (MEMREF_COPY_CHECKSUM_EN only)
//
// SIZE must be at least 2 so that the address width is non-zero.

module memref_copy_initiator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 8,
    localparam int unsigned AW   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tstart,
    input  logic [AW:0]      len,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic             rd_dout_valid,
    input  logic [WIDTH-1:0] rd_dout,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_din,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef MEMREF_COPY_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    localparam logic [AW:0] SizeW = (AW + 1)'(SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [AW:0]      n_q, n_d;      // clamped word count of the current copy
    logic [AW:0]      cnt_q, cnt_d;  // next read index to issue
    logic             rd_en_q, rd_en_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    // Second stage of the address pipeline; the first stage is rd_en/rd_addr
    // themselves. This stage lines up with the returning read data.
    logic             pipe_vld_q, pipe_vld_d;
    logic [AW-1:0]    pipe_addr_q, pipe_addr_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_din_q, wr_din_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [AW:0]      len_clamped;

    assign len_clamped = (len > SizeW) ? SizeW : len;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        pipe_vld_d  = rd_en_q;
        pipe_addr_d = rd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_din_d    = wr_din_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        csum_d      = csum_q;

        // Write side: only words that were both expected and delivered are
        // written; a missing word is skipped without stalling the copy.
        if (pipe_vld_q && rd_dout_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pipe_addr_q;
            wr_din_d  = rd_dout;
            csum_d    = csum_q + rd_dout;
        end

        if (rd_dout_valid != pipe_vld_q) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (tstart) begin
                    csum_d = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d       = len_clamped;
                        cnt_d     = (AW + 1)'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
                        state_d   = StIssue;
                    end
                end
            end

            StIssue: begin
                if (cnt_q == n_q) begin
                    rd_en_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    rd_addr_d = cnt_q[AW-1:0];
                    cnt_d     = cnt_q + (AW + 1)'(1);
                end
            end

            StDrain: begin
                // The last expected word has left the pipeline once both
                // stages are empty.
                if (!rd_en_q && !pipe_vld_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            n_q         <= '0;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_din_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            csum_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_din_q    <= wr_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            csum_q      <= csum_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_din  = wr_din_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

`ifdef MEMREF_COPY_CHECKSUM_EN
    assign checksum = csum_q;
`else
    // Without the checksum port the accumulator has no observer and is
    // removed by synthesis.
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_memref_copy_initiator.sv
// Self-checking bench for memref_copy_initiator: a source memory responder
// with optional dropped valid, a destination memory, and a per-cycle
// reference built from the copy's timing rules and a shadow destination array.

module tb_memref_copy_initiator;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned AW    = $clog2(SIZE);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tstart = 1'b0;
    logic [AW:0]      len = '0;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_dout_valid;
    logic [WIDTH-1:0] rd_dout;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_din;
    logic             busy;
    logic             done;
    logic             err;
`ifdef MEMREF_COPY_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] src [SIZE];
    logic [WIDTH-1:0] dst [SIZE];
    logic [WIDTH-1:0] exp_dst [SIZE];
    int               drop_a = -1;
    logic             init_done = 1'b0;
    logic             err_model = 1'b0;
    logic [WIDTH-1:0] csum_model = '0;

    memref_copy_initiator #(
        .WIDTH(WIDTH),
        .SIZE (SIZE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tstart       (tstart),
        .len          (len),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_dout_valid(rd_dout_valid),
        .rd_dout      (rd_dout),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_din       (wr_din),
        .busy         (busy),
        .done         (done),
        .err          (err)
`ifdef MEMREF_COPY_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Source memory responder: latency 1, can withhold valid for one address.
    always @(posedge clk) begin
        rd_dout_valid <= rd_en && !(int'(rd_addr) == drop_a);
        rd_dout       <= src[rd_addr];
    end

    // Destination memory.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < SIZE; i++) dst[i] <= 32'hDEAD_0000 + i;
        end else if (wr_en) begin
            dst[wr_addr] <= wr_din;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_en"}, 64'(rd_en), 64'd0);
        check({tag, ".rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, ".wr_en"}, 64'(wr_en), 64'd0);
        check({tag, ".wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, ".wr_din"}, 64'(wr_din), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".err"}, 64'(err), 64'd0);
`ifdef MEMREF_COPY_CHECKSUM_EN
        check({tag, ".checksum"}, 64'(checksum), 64'd0);
`endif
    endtask

    task automatic check_dst(input string tag);
        for (int i = 0; i < SIZE; i++) begin
            check($sformatf("%s.dst%0d", tag, i), 64'(dst[i]), 64'(exp_dst[i]));
        end
    endtask

    // One copy. Called #1 after an edge (or at a negedge). repulse_c/rst_c
    // are the cycle indices (edge 0 = start sample) at which tstart is
    // re-pulsed or reset is asserted; -1 disables them.
    task automatic run_copy(input string tag, input int l, input int drop, input int repulse_c,
                            input int rst_c);
        int  n;
        int  last;
        int  k;
        bit  wr_exp;
        bit  aborted;
        int  done_c;
        n       = (l > int'(SIZE)) ? int'(SIZE) : l;
        last    = (n == 0) ? 3 : n + 4;
        done_c  = (n == 0) ? 0 : n + 2;
        aborted = 1'b0;
        drop_a  = drop;
        len     = (AW + 1)'(l);
        tstart  = 1'b1;
        csum_model = '0;
        if (n > 0) err_model = 1'b0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            tstart = (c == repulse_c);
            check($sformatf("%s.c%0d.rd_en", tag, c), 64'(rd_en), 64'(c < n));
            if (c < n) check($sformatf("%s.c%0d.rd_addr", tag, c), 64'(rd_addr), 64'(c));
            k      = c - 2;
            wr_exp = (k >= 0) && (k < n) && (k != drop);
            check($sformatf("%s.c%0d.wr_en", tag, c), 64'(wr_en), 64'(wr_exp));
            if (wr_exp) begin
                check($sformatf("%s.c%0d.wr_addr", tag, c), 64'(wr_addr), 64'(k));
                check($sformatf("%s.c%0d.wr_din", tag, c), 64'(wr_din), 64'(src[k]));
            end
            check($sformatf("%s.c%0d.done", tag, c), 64'(done), 64'(c == done_c));
            check($sformatf("%s.c%0d.busy", tag, c), 64'(busy), 64'(n > 0 && c <= n + 1));
            if (drop >= 0 && drop < n && c >= drop + 2) err_model = 1'b1;
            check($sformatf("%s.c%0d.err", tag, c), 64'(err), 64'(err_model));
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, ".async_rst"});
                // Words whose write was already captured by the destination.
                for (int j = 0; j < n && j <= rst_c - 3; j++) exp_dst[j] = src[j];
                err_model = 1'b0;
                aborted   = 1'b1;
                break;
            end
        end
        tstart = 1'b0;
        drop_a = -1;
        if (!aborted) begin
            for (int j = 0; j < n; j++) begin
                if (j != drop) begin
                    exp_dst[j] = src[j];
                    csum_model = csum_model + src[j];
                end
            end
            check_dst(tag);
`ifdef MEMREF_COPY_CHECKSUM_EN
            check({tag, ".checksum"}, 64'(checksum), 64'(csum_model));
`endif
        end
    endtask

    task automatic randomize_src();
        for (int i = 0; i < SIZE; i++) src[i] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            src[i]     = 32'(10 + i);
            exp_dst[i] = 32'hDEAD_0000 + i;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        init_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_copy("copy8", 8, -1, -1, -1);
`ifdef MEMREF_COPY_CHECKSUM_EN
        check("copy8.sum108", 64'(checksum), 64'd108);
`endif
        run_copy("len0", 0, -1, -1, -1);
        run_copy("len12", 12, -1, -1, -1);
        run_copy("repulse", 8, -1, 3, -1);

        randomize_src();
        run_copy("drop4", 8, 4, -1, -1);
        randomize_src();
        run_copy("after_drop", 8, -1, -1, -1);

        randomize_src();
        run_copy("rst5", 8, -1, -1, 5);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst.c%0d.done", c), 64'(done), 64'd0);
            check($sformatf("post_rst.c%0d.busy", c), 64'(busy), 64'd0);
            check($sformatf("post_rst.c%0d.rd_en", c), 64'(rd_en), 64'd0);
        end
        randomize_src();
        run_copy("after_rst", 8, -1, -1, -1);

        for (int r = 0; r < 6; r++) begin
            randomize_src();
            run_copy($sformatf("rand%0d", r), int'($urandom_range(0, 15)), -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
